// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    // Fetch sequencing states: issue a request, wait for its response,
    // or park a response that the decode stage could not take yet.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_INC      = 4;
    localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load > bubble.
module if_id_reg
    import if_pkg::*;
#(
    parameter int          PC_WIDTH  = 10,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_flush,
    input  logic                i_hold,
    input  logic                i_load,
    input  logic [31:0]         i_instr,
    input  logic [PC_WIDTH-1:0] i_pc_plus4,
    output logic [31:0]         o_instr,
    output logic [PC_WIDTH-1:0] o_pc_plus4,
    output logic                o_valid
);

    logic [31:0]         r_instr;
    logic [PC_WIDTH-1:0] r_pc_plus4;
    logic                r_valid;

    // pc_plus4 is only meaningful while valid, so bubbles leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_hold) begin
            r_instr <= r_instr;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end else begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: single-outstanding fetch FSM feeding IF/ID.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FETCH | request at pc offered to memory; responses here are stale
// WAIT  | request accepted, waiting for its response (squash = discard it)
// HOLD  | response parked in hold buffer until decode accepts it
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int                  PC_WIDTH  = 10,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]         NOP_INSTR = DEFAULT_NOP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_address,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_address,
    input  logic                Data_Hazard,
    input  logic                IF_Flush,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic                if_id_valid
);

    fetch_state_t        r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_squash;
    logic                r_req_en;
    logic [31:0]         r_hold_data;

    fetch_state_t        w_state_nxt;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic                w_squash_nxt;
    logic                w_hold_we;
    logic                w_load;
    logic [31:0]         w_load_data;
    logic                w_req_valid;

    logic                w_adv;
    logic                w_redir;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic                w_accept;

    assign w_adv    = Data_Hazard;
    assign w_redir  = w_adv & (jump | branch_taken);
    assign w_target = jump ? jump_address : branch_address;
    assign w_pc_inc = r_pc + PC_WIDTH'(PC_INC);
    assign w_accept = w_req_valid & imem_req_ready;

    // State, PC and hold-buffer registers; r_req_en delays the first
    // request by one edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= FETCH;
            r_pc        <= RESET_PC;
            r_squash    <= 1'b0;
            r_req_en    <= 1'b0;
            r_hold_data <= NOP_INSTR;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_squash <= w_squash_nxt;
            r_req_en <= 1'b1;
            if (w_hold_we) begin
                r_hold_data <= imem_rsp_data;
            end
        end
    end

    // Next-state, PC update and IF/ID load selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_squash_nxt = r_squash;
        w_hold_we    = 1'b0;
        w_load       = 1'b0;
        w_load_data  = r_hold_data;
        w_req_valid  = 1'b0;

        case (r_state)
            FETCH: begin
                w_req_valid = r_req_en;
                if (w_accept) begin
                    w_state_nxt  = WAIT;
                    w_squash_nxt = w_redir;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = FETCH;
                    if (r_squash) begin
                        w_squash_nxt = 1'b0;
                    end else if (w_redir) begin
                        w_squash_nxt = 1'b0;
                    end else if (w_adv && !IF_Flush) begin
                        w_load      = 1'b1;
                        w_load_data = imem_rsp_data;
                        w_pc_nxt    = w_pc_inc;
                    end else begin
                        w_hold_we   = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else if (w_redir) begin
                    w_squash_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (w_redir) begin
                    w_state_nxt = FETCH;
                end else if (w_adv && !IF_Flush) begin
                    w_load      = 1'b1;
                    w_load_data = r_hold_data;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase

        // A redirect always retargets the PC, whatever else happens.
        if (w_redir) begin
            w_pc_nxt = w_target;
        end
    end

    if_id_reg #(
        .PC_WIDTH  (PC_WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (reset),
        .i_flush    (IF_Flush | w_redir),
        .i_hold     (~w_adv),
        .i_load     (w_load),
        .i_instr    (w_load_data),
        .i_pc_plus4 (w_pc_inc),
        .o_instr    (instr),
        .o_pc_plus4 (pc_plus4),
        .o_valid    (if_id_valid)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_pc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_if_fetch_stage;

    localparam int          PCW = 10;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           branch_taken = 1'b0;
    logic [PCW-1:0] branch_address = '0;
    logic           jump = 1'b0;
    logic [PCW-1:0] jump_address = '0;
    logic           Data_Hazard = 1'b1;
    logic           IF_Flush = 1'b0;
    logic           imem_req_valid;
    logic           imem_req_ready = 1'b0;
    logic [PCW-1:0] imem_addr;
    logic           imem_rsp_valid = 1'b0;
    logic [31:0]    imem_rsp_data = '0;
    logic [31:0]    instr;
    logic [PCW-1:0] pc_plus4;
    logic           if_id_valid;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .PC_WIDTH  (PCW),
        .RESET_PC  (10'h000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .jump           (jump),
        .jump_address   (jump_address),
        .Data_Hazard    (Data_Hazard),
        .IF_Flush       (IF_Flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .pc_plus4       (pc_plus4),
        .if_id_valid    (if_id_valid)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // memory behaviour
    bit             mem_busy;
    int             mem_cnt;
    logic [PCW-1:0] mem_addr;
    int             mem_lat = 1;
    bit             force_rsp = 1'b0;

    // reference model: fetch address, in-flight request, parked word, IF/ID
    logic [PCW-1:0] m_pc;
    bit             m_started;
    bit             m_out;
    bit             m_kill;
    bit             m_parked;
    logic [31:0]    m_park_data;
    logic [31:0]    m_instr;
    logic [PCW-1:0] m_pc4;
    bit             m_valid;

    function automatic logic [31:0] mem_word(input logic [PCW-1:0] a);
        if (a == 10'h000) return 32'h2008_0005;
        return 32'h5A3C_0000 ^ {6'h15, a, 6'h2A, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 10'h000; m_started = 0; m_out = 0; m_kill = 0; m_parked = 0;
        m_park_data = NOP; m_instr = NOP; m_pc4 = '0; m_valid = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = '0;
    endtask

    task automatic check_outputs();
        chk("req_valid", 32'(imem_req_valid), 32'(m_started && !m_out && !m_parked));
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        chk("instr", instr, m_instr);
        if (m_valid) chk("pc_plus4", 32'(pc_plus4), 32'(m_pc4));
    endtask

    // One clock: present memory response, advance model and memory, then check.
    task automatic step();
        bit             rsp, adv, redir, req, acc, deliver, was_parked;
        logic [PCW-1:0] tgt, addr0;
        logic [31:0]    rdat, dat;

        rsp            = force_rsp || (mem_busy && mem_cnt == 0);
        rdat           = force_rsp ? 32'hDEAD_BEEF : mem_word(mem_addr);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdat;

        adv        = Data_Hazard;
        redir      = adv && (jump || branch_taken);
        tgt        = jump ? jump_address : branch_address;
        addr0      = m_pc;
        req        = m_started && !m_out && !m_parked;
        acc        = req && imem_req_ready;
        was_parked = m_parked;
        deliver    = 0;
        dat        = NOP;

        if (m_out && rsp) begin
            if (!m_kill && !redir) begin
                if (adv && !IF_Flush) begin
                    deliver = 1; dat = rdat;
                end else begin
                    m_parked = 1; m_park_data = rdat;
                end
            end
            m_out = 0; m_kill = 0;
        end else if (m_out && redir) begin
            m_kill = 1;
        end
        if (was_parked) begin
            if (redir) m_parked = 0;
            else if (adv && !IF_Flush) begin
                deliver = 1; dat = m_park_data; m_parked = 0;
            end
        end
        if (acc) begin
            m_out = 1; m_kill = redir;
        end

        if (IF_Flush || redir) begin
            m_instr = NOP; m_valid = 0;
        end else if (adv) begin
            if (deliver) begin
                m_instr = dat; m_pc4 = m_pc + 10'd4; m_valid = 1;
            end else begin
                m_instr = NOP; m_valid = 0;
            end
        end
        if (redir) m_pc = tgt;
        else if (deliver) m_pc = m_pc + 10'd4;
        m_started = 1;

        if (rsp && !force_rsp) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (acc) begin
            mem_busy = 1; mem_cnt = mem_lat - 1; mem_addr = addr0;
        end

        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_instr", instr, NOP);
        chk("rst_pc_plus4", 32'(pc_plus4), 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // first fetch from RESET_PC with a zero-wait memory
        imem_req_ready = 1; mem_lat = 1;
        step();
        chk("t1_req_issue", 32'(imem_req_valid), 32'h1);
        step();
        step();
        chk("t1_instr", instr, 32'h2008_0005);
        chk("t1_pc_plus4", 32'(pc_plus4), 32'h004);
        chk("t1_valid", 32'(if_id_valid), 32'h1);
        chk("t1_next_addr", 32'(imem_addr), 32'h004);

        // stall for three cycles while the response for 0x004 arrives
        Data_Hazard = 0;
        step(); step(); step();
        chk("t2_held_instr", instr, 32'h2008_0005);
        chk("t2_pc_frozen", 32'(imem_addr), 32'h004);
        Data_Hazard = 1;
        step();
        chk("t2_release_instr", instr, mem_word(10'h004));
        chk("t2_release_pc4", 32'(pc_plus4), 32'h008);
        chk("t2_release_addr", 32'(imem_addr), 32'h008);

        // jump while waiting on 0x008
        mem_lat = 2;
        step();
        jump = 1; jump_address = 10'h040;
        step();
        chk("t3_flush_valid", 32'(if_id_valid), 32'h0);
        chk("t3_flush_instr", instr, NOP);
        jump = 0;
        step();
        chk("t3_retarget", 32'(imem_addr), 32'h040);
        mem_lat = 1;
        step(); step();
        chk("t3_target_instr", instr, mem_word(10'h040));

        // jump beats branch; stalled redirect is ignored
        imem_req_ready = 0; Data_Hazard = 0;
        jump = 1; jump_address = 10'h100; branch_taken = 1; branch_address = 10'h080;
        step();
        chk("t4_stalled_redirect", 32'(imem_addr), 32'h044);
        Data_Hazard = 1;
        step();
        chk("t4_jump_priority", 32'(imem_addr), 32'h100);
        jump = 0; branch_taken = 0;
        imem_req_ready = 1;
        step(); step();

        // PC wrap at the top of the address space
        imem_req_ready = 0; jump = 1; jump_address = 10'h3FC;
        step();
        jump = 0; imem_req_ready = 1;
        step(); step();
        chk("t5_wrap_pc4", 32'(pc_plus4), 32'h000);
        chk("t5_wrap_addr", 32'(imem_addr), 32'h000);
        chk("t5_wrap_instr", instr, mem_word(10'h3FC));

        // reset while a request is outstanding, then a stray response
        mem_lat = 3;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(if_id_valid), 32'h0);
        chk("t6_rst_req", 32'(imem_req_valid), 32'h0);
        chk("t6_rst_addr", 32'(imem_addr), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        imem_req_ready = 0; force_rsp = 1;
        step(); step();
        force_rsp = 0; imem_req_ready = 1; mem_lat = 1;
        step(); step();
        chk("t6_first_instr", instr, 32'h2008_0005);
        chk("t6_first_pc4", 32'(pc_plus4), 32'h004);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            Data_Hazard    = ($urandom_range(0, 3) != 0);
            IF_Flush       = ($urandom_range(0, 9) == 0);
            jump           = ($urandom_range(0, 11) == 0);
            branch_taken   = ($urandom_range(0, 9) == 0);
            jump_address   = {8'($urandom_range(0, 255)), 2'b00};
            branch_address = {8'($urandom_range(0, 255)), 2'b00};
            imem_req_ready = ($urandom_range(0, 3) != 0);
            mem_lat        = int'($urandom_range(1, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that produces the IF/ID pipeline register (instr, pc_plus4) consumed by the decode stage.
- Consumes the decode stage's redirect outputs: branch_taken/branch_address, jump/jump_address.
- Consumes the hazard controls: Data_Hazard (active-low stall) and IF_Flush.
- Fetches from a variable-latency instruction memory over a valid/ready request and valid response handshake, with at most one request outstanding.

Parameters:
PC_WIDTH, 10, width of the PC and of all instruction addresses
RESET_PC, 10'h000, PC value loaded on reset
NOP_INSTR, 32'h00000000, bubble value driven into IF/ID on flush or empty fetch

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
branch_taken  input  1  decode-stage branch resolved taken
branch_address  input  PC_WIDTH  branch target
jump  input  1  decode-stage jump
jump_address  input  PC_WIDTH  jump target
Data_Hazard  input  1  active-low stall: 0 = hold IF/ID and PC, 1 = advance
IF_Flush  input  1  squash IF/ID contents this cycle
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  PC_WIDTH  fetch byte address, equal to the current PC
imem_rsp_valid  input  1  response data valid, one pulse per accepted request
imem_rsp_data  input  32  fetched instruction
instr  output  32  IF/ID instruction
pc_plus4  output  PC_WIDTH  IF/ID PC+4
if_id_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=FETCH, squash=0, hold buffer empty.
  - instr=NOP_INSTR, pc_plus4=0, if_id_valid=0, imem_req_valid=0.
  - After release, the first request is issued on the next edge.
- Advance condition: adv = Data_Hazard (1 = the ID stage accepts).
- Redirect: redir = adv & (jump | branch_taken). Target = jump ? jump_address : branch_address, so jump has priority.
- Redirects are ignored while stalled (Data_Hazard=0).
- States:
  - FETCH: imem_req_valid=1, imem_addr=pc.
    - req accepted (valid&ready) -> WAIT.
    - redir in the same cycle as acceptance: squash<=1 and pc<=target.
    - redir without acceptance: pc<=target. The request is retargeted; memory samples address only on valid&ready.
    - imem_rsp_valid in FETCH is ignored, which covers stale responses after reset.
  - WAIT: imem_req_valid=0.
    - On rsp_valid with squash=1: discard the data, squash<=0, -> FETCH.
    - On rsp_valid with redir in the same cycle: discard the data, pc<=target, -> FETCH.
    - On rsp_valid when adv & !IF_Flush: IF/ID<={data, pc+4}, if_id_valid=1, pc<=pc+4, -> FETCH.
    - On rsp_valid otherwise (stall or IF_Flush): store data in the hold buffer, -> HOLD.
    - redir without rsp_valid: squash<=1, pc<=target, stay in WAIT.
  - HOLD: imem_req_valid=0.
    - adv & !redir & !IF_Flush: load IF/ID from the buffer, pc<=pc+4, -> FETCH.
    - redir: drop the buffer, pc<=target, -> FETCH.
- IF/ID register:
  - IF_Flush or redir: instr<=NOP_INSTR, if_id_valid<=0. This has priority over loads.
  - Stall (adv=0, no flush): hold the current value.
  - adv with nothing to load: bubble (NOP_INSTR, valid 0).
- Arithmetic: pc+4 is computed modulo 2^PC_WIDTH, so 10'h3FC wraps to 10'h000. Targets are used verbatim.
- Latency: with a zero-wait memory (ready=1, rsp one cycle later), instr appears 2 cycles after request issue. Throughput is one instruction per 2 cycles.
- Reset mid-WAIT: the outstanding response is dropped because FETCH ignores rsp_valid.

Decomposition:
- Package if_pkg: fetch state enum (FETCH, WAIT, HOLD), PC_INC=4, default NOP_INSTR.
- Sub-module if_id_reg: IF/ID pipeline register with load/hold/flush controls and async active-low reset. Used by the top FSM.

Test Plan:
- Reset release, ready=1, rsp 1 cycle later with data 0x20080005 at addr 0 -> instr=0x20080005, pc_plus4=4, if_id_valid=1 on cycle 3. Next imem_addr=4.
- Data_Hazard=0 for 3 cycles while a response arrives -> IF/ID held, data parked in HOLD. When Data_Hazard=1, instr updates on the next edge and pc advances by 4 exactly once.
- jump=1, jump_address=0x040 while in WAIT for addr 0x008 -> IF/ID=NOP, valid=0. The response for 0x008 is discarded and the next imem_addr=0x040.
- jump=1 (0x100) and branch_taken=1 (0x080) together -> next fetch at 0x100. With Data_Hazard=0 in the same cycle, no redirect occurs.
- PC=0x3FC fetch completes -> pc_plus4=0x000, next imem_addr=0x000.
- Assert reset=0 during WAIT, release, then drive a stray rsp_valid -> ignored. The first instr comes from RESET_PC.
